rtc_bus_sequencer: RTL

Sequences every transaction on the multiplexed address/data bus to the RTC. Generates the chip strobes and drives the address bus (ADRESS). Also drives the phase flags (BEnv_Adress, BEnv_Data, BRes_Data) that tell the register/mux block when to drive or sample the Multiplex bus. Arbitrates between three sources:
- a fixed power-up init sequence;
- write requests from the general FSM;
- a background round-robin read scan that refreshes the display registers.

---
 rtl/rtc_bus_sequencer_if.sv | 30 +++
 rtl/rtc_bus_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_sequencer_if.sv
// Handshake and multiplexed-bus signal bundle between the RTC bus sequencer,
// the general FSM (write requests) and the register/mux block.
interface rtc_bus_sequencer_if;
    logic       scan_en;
    logic       wr_req;
    logic [7:0] wr_adress;
    logic       wr_done;
    logic       init_done;
    logic       busy;
    logic       CS_n;
    logic       AD;
    logic       WR_n;
    logic       RD_n;
    logic [7:0] ADRESS;
    logic       BEnv_Adress;
    logic       BEnv_Data;
    logic       BRes_Data;

    modport master (
        input  scan_en, wr_req, wr_adress,
        output wr_done, init_done, busy, CS_n, AD, WR_n, RD_n, ADRESS,
               BEnv_Adress, BEnv_Data, BRes_Data
    );

    modport slave (
        output scan_en, wr_req, wr_adress,
        input  wr_done, init_done, busy, CS_n, AD, WR_n, RD_n, ADRESS,
               BEnv_Adress, BEnv_Data, BRes_Data
    );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// RTC bus sequencer: arbitrates init writes, FSM writes and a background read scan.
// Define TIMER_SCAN_EN to add the timer registers 8'h41-8'h43 to the read scan.
module rtc_bus_sequencer #(
    parameter int unsigned T_PHASE   = 10,
    parameter logic [7:0]  ADDR_IDLE = 8'hFF
) (
    input  logic                CLK,
    input  logic                RST,
    rtc_bus_sequencer_if.master bus
);
    localparam int unsigned   PW         = $clog2(T_PHASE);
    localparam logic [PW-1:0] PHASE_LAST = PW'(T_PHASE - 1);
    localparam logic [7:0]    INIT_ADDR  = 8'h02;
`ifdef TIMER_SCAN_EN
    localparam logic [3:0]    SCAN_LAST  = 4'd8;
`else
    localparam logic [3:0]    SCAN_LAST  = 4'd5;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_A_STRB = 3'd1,
        S_A_REC  = 3'd2,
        S_D_STRB = 3'd3,
        S_D_REC  = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SRC_INIT = 2'd0,
        SRC_WR   = 2'd1,
        SRC_SCAN = 2'd2
    } src_t;

    function automatic logic [7:0] scan_addr(input logic [3:0] idx);
        case (idx)
            4'd0:    scan_addr = 8'h21;
            4'd1:    scan_addr = 8'h22;
            4'd2:    scan_addr = 8'h23;
            4'd3:    scan_addr = 8'h24;
            4'd4:    scan_addr = 8'h25;
            4'd5:    scan_addr = 8'h26;
            4'd6:    scan_addr = 8'h41;
            4'd7:    scan_addr = 8'h42;
            4'd8:    scan_addr = 8'h43;
            default: scan_addr = 8'h21;
        endcase
    endfunction

    function automatic state_t next_phase(input state_t st);
        case (st)
            S_A_STRB: next_phase = S_A_REC;
            S_A_REC:  next_phase = S_D_STRB;
            S_D_STRB: next_phase = S_D_REC;
            S_D_REC:  next_phase = S_GAP;
            default:  next_phase = S_IDLE;
        endcase
    endfunction

    state_t        state_r, state_s;
    src_t          src_r, src_s;
    logic [PW-1:0] phase_r, phase_s;
    logic [7:0]    adress_r, adress_s;
    logic [1:0]    init_cnt_r;
    logic [3:0]    scan_idx_r;
    logic          init_done_r, wr_done_r;
    logic          start_s, fin_s, txn_wr_s;
    logic          cs_n_r, ad_r, wr_n_r, rd_n_r, benv_a_r, benv_d_r, bres_r, busy_r;
    logic          cs_n_s, ad_s, wr_n_s, rd_n_s, benv_a_s, benv_d_s, bres_s, busy_s;

    // Next-state, phase counter, arbitration and address selection
    always_comb begin
        state_s  = state_r;
        phase_s  = phase_r;
        src_s    = src_r;
        adress_s = adress_r;
        start_s  = 1'b0;
        fin_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                phase_s  = '0;
                adress_s = ADDR_IDLE;
                if (init_cnt_r != 2'd2) begin
                    start_s  = 1'b1;
                    src_s    = SRC_INIT;
                    adress_s = INIT_ADDR;
                end else if (bus.wr_req && !wr_done_r) begin
                    // the wr_done cycle itself never re-accepts the request being acknowledged
                    start_s  = 1'b1;
                    src_s    = SRC_WR;
                    adress_s = bus.wr_adress;
                end else if (bus.scan_en && init_done_r) begin
                    start_s  = 1'b1;
                    src_s    = SRC_SCAN;
                    adress_s = scan_addr(scan_idx_r);
                end else begin
                    start_s  = 1'b0;
                end
                if (start_s) begin
                    state_s = S_A_STRB;
                end else begin
                    state_s = S_IDLE;
                end
            end
            default: begin
                if (phase_r == PHASE_LAST) begin
                    phase_s = '0;
                    state_s = next_phase(state_r);
                    if (state_r == S_GAP) begin
                        fin_s    = 1'b1;
                        adress_s = ADDR_IDLE;
                    end else begin
                        fin_s    = 1'b0;
                    end
                end else begin
                    phase_s = phase_r + PW'(1);
                end
            end
        endcase
    end

    // Bus strobes and phase flags for the state being entered
    always_comb begin
        txn_wr_s = (src_s != SRC_SCAN);
        cs_n_s   = 1'b1;
        ad_s     = 1'b0;
        wr_n_s   = 1'b1;
        rd_n_s   = 1'b1;
        benv_a_s = 1'b0;
        benv_d_s = 1'b0;
        bres_s   = 1'b0;
        busy_s   = 1'b1;
        case (state_s)
            S_IDLE: busy_s = 1'b0;
            S_A_STRB: begin
                cs_n_s   = 1'b0;
                wr_n_s   = 1'b0;
                benv_a_s = 1'b1;
            end
            S_A_REC: begin
                cs_n_s   = 1'b0;
                benv_a_s = 1'b1;
            end
            S_D_STRB: begin
                cs_n_s = 1'b0;
                ad_s   = 1'b1;
                if (txn_wr_s) begin
                    wr_n_s   = 1'b0;
                    benv_d_s = 1'b1;
                end else begin
                    rd_n_s = 1'b0;
                    bres_s = 1'b1;
                end
            end
            S_D_REC: begin
                cs_n_s = 1'b0;
                ad_s   = 1'b1;
            end
            S_GAP:   busy_s = 1'b1;
            default: busy_s = 1'b0;
        endcase
    end

    // State register and registered bus outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r  <= S_IDLE;
            phase_r  <= '0;
            src_r    <= SRC_INIT;
            adress_r <= ADDR_IDLE;
            cs_n_r   <= 1'b1;
            ad_r     <= 1'b0;
            wr_n_r   <= 1'b1;
            rd_n_r   <= 1'b1;
            benv_a_r <= 1'b0;
            benv_d_r <= 1'b0;
            bres_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            phase_r  <= phase_s;
            src_r    <= src_s;
            adress_r <= adress_s;
            cs_n_r   <= cs_n_s;
            ad_r     <= ad_s;
            wr_n_r   <= wr_n_s;
            rd_n_r   <= rd_n_s;
            benv_a_r <= benv_a_s;
            benv_d_r <= benv_d_s;
            bres_r   <= bres_s;
            busy_r   <= busy_s;
        end
    end

    // Completion bookkeeping: init progress, scan index, write acknowledge
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            init_cnt_r  <= 2'd0;
            init_done_r <= 1'b0;
            scan_idx_r  <= 4'd0;
            wr_done_r   <= 1'b0;
        end else begin
            wr_done_r <= fin_s && (src_r == SRC_WR);
            if (fin_s && (src_r == SRC_INIT) && (init_cnt_r != 2'd2)) begin
                init_cnt_r <= init_cnt_r + 2'd1;
            end
            if (fin_s && (src_r == SRC_INIT) && (init_cnt_r == 2'd1)) begin
                init_done_r <= 1'b1;
            end
            if (fin_s && (src_r == SRC_SCAN)) begin
                scan_idx_r <= (scan_idx_r == SCAN_LAST) ? 4'd0 : scan_idx_r + 4'd1;
            end
        end
    end

    assign bus.CS_n        = cs_n_r;
    assign bus.AD          = ad_r;
    assign bus.WR_n        = wr_n_r;
    assign bus.RD_n        = rd_n_r;
    assign bus.BEnv_Adress = benv_a_r;
    assign bus.BEnv_Data   = benv_d_r;
    assign bus.BRes_Data   = bres_r;
    assign bus.busy        = busy_r;
    assign bus.ADRESS      = adress_r;
    assign bus.wr_done     = wr_done_r;
    assign bus.init_done   = init_done_r;

endmodule
